riscv_mmio_router: RTL and testbench



---
 rtl/riscv_mmio_router_pkg.sv | 24 ++
 rtl/riscv_mmio_router_sync_fifo.sv | 69 ++++++
 rtl/riscv_mmio_router.sv | 150 +++++++++++++++
 tb/tb_riscv_mmio_router.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mmio_router_pkg.sv
// Shared MMIO offsets, status bit positions and decode helper for riscv_mmio_router.
// The optional cycle counter at MMIO_CYCLE exists only when MMIO_CYCLE_COUNTER_EN is defined.
package riscv_mmio_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

    localparam logic [7:0] MMIO_LED       = 8'h00;
    localparam logic [7:0] MMIO_SW        = 8'h04;
    localparam logic [7:0] MMIO_TX_DATA   = 8'h08;
    localparam logic [7:0] MMIO_TX_STATUS = 8'h0C;
    localparam logic [7:0] MMIO_CYCLE     = 8'h10;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_W   = 4;

    // Byte offset inside the aliased 256-byte MMIO window.
    function automatic logic [7:0] mmio_offset(input logic [5:0] word_off);
        return {word_off, 2'b00};
    endfunction

endpackage

// File: rtl/riscv_mmio_router_sync_fifo.sv
// Synchronous FIFO with registered count; pushes when full and pops when empty are ignored.
// The head output reads zero while empty so it is clean straight out of reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push_in,
    input  logic                     pop_in,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full_out,
    output logic                     empty_out,
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_out  = (count_q == CNT_W'(DEPTH));
    assign empty_out = (count_q == '0);
    assign count_out = count_q;
    assign data_out  = empty_out ? '0 : mem_q[rd_ptr_q];

    assign push_ok = push_in && !full_out;
    assign pop_ok  = pop_in && !empty_out;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers and count.
    always_ff @(posedge clk_in) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/riscv_mmio_router.sv
// Routes CPU word accesses to BRAM or the LED/SW/UART-TX MMIO bank with a fixed 2-cycle read latency.
// Define MMIO_CYCLE_COUNTER_EN to add a read-only free-running cycle counter at offset 0x10.
module riscv_mmio_router
    import riscv_mmio_pkg::*;
#(
    parameter int          BRAM_ADDR_W   = 14,
    parameter logic [31:0] MMIO_BASE     = MMIO_BASE_DEFAULT,
    parameter int          TX_FIFO_DEPTH = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [31:0]            mem_addr_in,
    input  logic [31:0]            mem_data_in,
    input  logic [3:0]             mem_write_enable_in,
    output logic [31:0]            mem_data_out,
    output logic [BRAM_ADDR_W-1:0] bram_addr_out,
    output logic [31:0]            bram_data_out,
    output logic [3:0]             bram_we_out,
    input  logic [31:0]            bram_data_in,
    input  logic [15:0]            sw_in,
    output logic [15:0]            led_out,
    output logic [7:0]             tx_data_out,
    output logic                   tx_valid_out,
    input  logic                   tx_ready_in
);

    localparam int CNT_W = $clog2(TX_FIFO_DEPTH) + 1;

    logic             sel_mmio;
    logic [7:0]       offset;
    logic [31:0]      mmio_rd;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             w1c_ovf;

    logic [15:0] led_q, led_d;
    logic        overflow_q, overflow_d;
    logic        sel_s1_q, sel_s1_d;
    logic        sel_s2_q, sel_s2_d;
    logic [31:0] rd_s1_q, rd_s1_d;
    logic [31:0] rd_s2_q, rd_s2_d;
    logic [1:0]  live_q, live_d;
    logic [31:0] cycle_cnt;

    assign sel_mmio      = (mem_addr_in[31] == MMIO_BASE[31]);
    assign offset        = mmio_offset(mem_addr_in[7:2]);
    assign bram_addr_out = mem_addr_in[BRAM_ADDR_W+1:2];
    assign bram_data_out = mem_data_in;
    assign bram_we_out   = sel_mmio ? 4'b0000 : mem_write_enable_in;

    assign fifo_push = sel_mmio && (offset == MMIO_TX_DATA) && mem_write_enable_in[0];
    assign w1c_ovf   = sel_mmio && (offset == MMIO_TX_STATUS) && mem_write_enable_in[0]
                       && mem_data_in[STAT_OVERFLOW];
    assign fifo_pop  = tx_valid_out && tx_ready_in;
    assign tx_valid_out = !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push_in   (fifo_push),
        .pop_in    (fifo_pop),
        .data_in   (mem_data_in[7:0]),
        .data_out  (tx_data_out),
        .full_out  (fifo_full),
        .empty_out (fifo_empty),
        .count_out (fifo_count)
    );

`ifdef MMIO_CYCLE_COUNTER_EN
    logic [31:0] cycle_q, cycle_d;
    assign cycle_d   = cycle_q + 32'd1;
    assign cycle_cnt = cycle_q;
    always_ff @(posedge clk_in) begin
        if (rst_in) cycle_q <= '0;
        else        cycle_q <= cycle_d;
    end
`else
    assign cycle_cnt = '0;
`endif

    // Read mux samples state before this cycle's writes take effect.
    always_comb begin
        mmio_rd = '0;
        case (offset)
            MMIO_LED:       mmio_rd = {16'b0, led_q};
            MMIO_SW:        mmio_rd = {16'b0, sw_in};
            MMIO_TX_STATUS: begin
                mmio_rd[STAT_EMPTY]    = fifo_empty;
                mmio_rd[STAT_FULL]     = fifo_full;
                mmio_rd[STAT_OVERFLOW] = overflow_q;
                mmio_rd[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
            end
            MMIO_CYCLE:     mmio_rd = cycle_cnt;
            default:        mmio_rd = '0;
        endcase
    end

    always_comb begin
        led_d      = led_q;
        overflow_d = overflow_q;
        if (sel_mmio && (offset == MMIO_LED)) begin
            if (mem_write_enable_in[0]) led_d[7:0]  = mem_data_in[7:0];
            if (mem_write_enable_in[1]) led_d[15:8] = mem_data_in[15:8];
        end
        if (fifo_push && fifo_full) overflow_d = 1'b1;
        else if (w1c_ovf)           overflow_d = 1'b0;
    end

    // live_q gates the output to zero until two post-reset reads have flowed through.
    always_comb begin
        sel_s1_d = sel_mmio;
        rd_s1_d  = mmio_rd;
        sel_s2_d = sel_s1_q;
        rd_s2_d  = rd_s1_q;
        live_d   = {live_q[0], 1'b1};
    end

    assign mem_data_out = !live_q[1] ? 32'b0 : (sel_s2_q ? rd_s2_q : bram_data_in);
    assign led_out      = led_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            led_q      <= '0;
            overflow_q <= 1'b0;
            sel_s1_q   <= 1'b0;
            sel_s2_q   <= 1'b0;
            rd_s1_q    <= '0;
            rd_s2_q    <= '0;
            live_q     <= '0;
        end else begin
            led_q      <= led_d;
            overflow_q <= overflow_d;
            sel_s1_q   <= sel_s1_d;
            sel_s2_q   <= sel_s2_d;
            rd_s1_q    <= rd_s1_d;
            rd_s2_q    <= rd_s2_d;
            live_q     <= live_d;
        end
    end

    logic addr_unused;
    assign addr_unused = ^{mem_addr_in[30:BRAM_ADDR_W+2], mem_addr_in[1:0]};

endmodule

// File: tb/tb_riscv_mmio_router.sv
// Self-checking bench for riscv_mmio_router: directed scenarios plus random traffic against a queue-based model.
// Honours MMIO_CYCLE_COUNTER_EN the same way the design does.
module tb_riscv_mmio_router;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] mem_addr_in = '0;
    logic [31:0] mem_data_in = '0;
    logic [3:0]  mem_write_enable_in = '0;
    logic [31:0] mem_data_out;
    logic [13:0] bram_addr_out;
    logic [31:0] bram_data_out;
    logic [3:0]  bram_we_out;
    logic [31:0] bram_data_in = '0;
    logic [15:0] sw_in = '0;
    logic [15:0] led_out;
    logic [7:0]  tx_data_out;
    logic        tx_valid_out;
    logic        tx_ready_in = 1'b0;

    riscv_mmio_router dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .mem_addr_in         (mem_addr_in),
        .mem_data_in         (mem_data_in),
        .mem_write_enable_in (mem_write_enable_in),
        .mem_data_out        (mem_data_out),
        .bram_addr_out       (bram_addr_out),
        .bram_data_out       (bram_data_out),
        .bram_we_out         (bram_we_out),
        .bram_data_in        (bram_data_in),
        .sw_in               (sw_in),
        .led_out             (led_out),
        .tx_data_out         (tx_data_out),
        .tx_valid_out        (tx_valid_out),
        .tx_ready_in         (tx_ready_in)
    );

    always #5 clk_in = ~clk_in;

    localparam int DEPTH = 8;

    // Attached BRAM (environment) and the reference model's own view of memory.
    logic [31:0] mem_env [16384];
    logic [31:0] mem_ref [16384];
    logic [31:0] env_p0 = '0;
    logic [31:0] env_p1 = '0;

    logic [15:0]  led_r;
    logic         ovf_r;
    logic [7:0]   fifo_r[$];
    int unsigned  cyc_r;
    logic [31:0]  exp_q[$];

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] v;
        v = '0;
        if (!a[31]) begin
            v = mem_ref[a[15:2]];
        end else begin
            case (a[7:2])
                6'd0: v = {16'b0, led_r};
                6'd1: v = {16'b0, sw_in};
                6'd3: begin
                    v[0]    = (fifo_r.size() == 0);
                    v[1]    = (fifo_r.size() == DEPTH);
                    v[2]    = ovf_r;
                    v[11:8] = 4'(fifo_r.size());
                end
`ifdef MMIO_CYCLE_COUNTER_EN
                6'd4: v = cyc_r;
`endif
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    task automatic env_bram_step();
        logic [31:0] rd;
        rd = mem_env[bram_addr_out];
        for (int b = 0; b < 4; b++)
            if (bram_we_out[b]) mem_env[bram_addr_out][8*b +: 8] = bram_data_out[8*b +: 8];
        env_p1 = env_p0;
        env_p0 = rd;
    endtask

    // One bus cycle: drive, check outputs, advance the model, wait for the next cycle.
    task automatic do_cycle(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] we, input logic rdy);
        logic [31:0] v;
        int          pre_cnt;
        mem_addr_in         = a;
        mem_data_in         = d;
        mem_write_enable_in = we;
        tx_ready_in         = rdy;
        bram_data_in        = env_p1;
        #1;
        check("bram_addr", 32'(bram_addr_out), 32'(a[15:2]));
        check("bram_we", 32'(bram_we_out), a[31] ? 32'd0 : 32'(we));
        check("bram_data", bram_data_out, d);
        check("rdata", mem_data_out, exp_q.pop_front());
        check("led", 32'(led_out), 32'(led_r));
        check("tx_valid", 32'(tx_valid_out), 32'(fifo_r.size() != 0));
        check("tx_data", 32'(tx_data_out), fifo_r.size() != 0 ? 32'(fifo_r[0]) : 32'd0);

        v = ref_read(a);
        exp_q.push_back(v);
        pre_cnt = fifo_r.size();
        if (rdy && pre_cnt > 0) void'(fifo_r.pop_front());
        if (a[31]) begin
            case (a[7:2])
                6'd0: begin
                    if (we[0]) led_r[7:0]  = d[7:0];
                    if (we[1]) led_r[15:8] = d[15:8];
                end
                6'd2: if (we[0]) begin
                    if (pre_cnt < DEPTH) fifo_r.push_back(d[7:0]);
                    else                 ovf_r = 1'b1;
                end
                6'd3: if (we[0] && d[2]) ovf_r = 1'b0;
                default: ;
            endcase
        end else begin
            for (int b = 0; b < 4; b++)
                if (we[b]) mem_ref[a[15:2]][8*b +: 8] = d[8*b +: 8];
        end
        cyc_r++;
        env_bram_step();
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        rst_in              = 1'b1;
        mem_addr_in         = '0;
        mem_data_in         = '0;
        mem_write_enable_in = '0;
        tx_ready_in         = 1'b0;
        bram_data_in        = env_p1;
        #1;
        env_bram_step();
        @(negedge clk_in);
        rst_in = 1'b0;
        led_r  = '0;
        ovf_r  = 1'b0;
        cyc_r  = 0;
        fifo_r.delete();
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) do_cycle(32'h0, 32'h0, 4'b0000, rdy);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem_env[i] = $urandom;
            mem_ref[i] = mem_env[i];
        end
        @(negedge clk_in);
        do_reset();
        do_reset();

        // BRAM word write then read back.
        do_cycle(32'h0000_0040, 32'h1234_ABCD, 4'b1111, 1'b0);
        do_cycle(32'h0000_0040, 32'h0, 4'b0000, 1'b0);
        idle(2, 1'b0);

        // LED lane writes.
        do_cycle(32'h8000_0000, 32'h0000_00FF, 4'b0011, 1'b0);
        do_cycle(32'h8000_0000, 32'h0000_5A00, 4'b0010, 1'b0);
        do_cycle(32'h8000_0000, 32'h0, 4'b0000, 1'b0);
        idle(2, 1'b0);

        // Fill FIFO, overflow, W1C, drain.
        for (int i = 0; i < 9; i++)
            do_cycle(32'h8000_0008, 32'(8'h41 + i), 4'b0001, 1'b0);
        do_cycle(32'h8000_000C, 32'h0, 4'b0000, 1'b0);
        do_cycle(32'h8000_000C, 32'h4, 4'b0001, 1'b0);
        do_cycle(32'h8000_000C, 32'h0, 4'b0000, 1'b0);
        for (int i = 0; i < 10; i++) do_cycle(32'h8000_000C, 32'h0, 4'b0000, 1'b1);
        idle(2, 1'b0);

        // Back-to-back reads across targets.
        sw_in = 16'hBEEF;
        do_cycle(32'h0000_0000, 32'h0, 4'b0000, 1'b0);
        do_cycle(32'h8000_0004, 32'h0, 4'b0000, 1'b0);
        do_cycle(32'h0000_0004, 32'h0, 4'b0000, 1'b0);
        idle(2, 1'b0);

        // Cycle counter reads five cycles apart.
        do_cycle(32'h8000_0010, 32'h0, 4'b0000, 1'b0);
        idle(4, 1'b0);
        do_cycle(32'h8000_0010, 32'h0, 4'b0000, 1'b0);
        idle(2, 1'b0);

        // Reset mid-operation.
        for (int i = 0; i < 3; i++) do_cycle(32'h8000_0008, 32'(8'h61 + i), 4'b0001, 1'b0);
        do_cycle(32'h8000_0000, 32'h0000_0077, 4'b0001, 1'b0);
        do_cycle(32'h8000_0000, 32'h0, 4'b0000, 1'b0);
        do_reset();
        do_cycle(32'h8000_000C, 32'h0, 4'b0000, 1'b0);
        idle(3, 1'b0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [3:0]  we;
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 3) == 0) sw_in = 16'($urandom);
                if ($urandom_range(0, 1) == 0)
                    a = {1'b0, 15'($urandom), 12'd0, 4'd0} | (32'($urandom_range(0, 15)) << 2)
                        | 32'($urandom_range(0, 3));
                else
                    a = {1'b1, 23'($urandom), 6'($urandom_range(0, 6)), 2'($urandom)};
                we = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
                do_cycle(a, $urandom, we, 1'($urandom_range(0, 2) == 0));
            end
        end
        idle(3, 1'b1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
